wb_stage: RTL
=============

# wb_stage

Writeback stage of the mips32 pipeline, consuming the MEM/WB register outputs. It selects the general-register write data, either the ALU result or the load data returned by data memory, byte/halfword-aligned and extended. It owns the architectural HI/LO registers and forwards CP0 writes. A two-state load-wait FSM stalls the pipeline when the data-memory response arrives late.

## Interface
Parameters:
- WAIT_CNT_W, 16, width of the saturating load-wait statistics counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- wb_dreg  in  32  ALU result / effective-address-derived value from MEM/WB
- wb_wa  in  5  destination GPR index
- wb_wreg  in  1  GPR write request
- wb_mreg  in  1  instruction is a load; data comes from dm_rdata
- wb_dre  in  4  byte-lane enables of the load (lane 0 = bits 7:0)
- wb_sext  in  1  load result is sign-extended (LB/LH); 0 = zero-extend (LBU/LHU)
- wb_whilo  in  1  HI/LO write request
- wb_hilo  in  64  HI (63:32) / LO (31:0) write data
- wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata  in  1/5/32  CP0 write request
- dm_rdata  in  32  data-memory read data
- dm_rvalid  in  1  dm_rdata valid this cycle
- rf_we, rf_wa, rf_wd  out  1/5/32  GPR write port
- hi_o, lo_o  out  32/32  HI/LO read values (bypassed)
- cp0_we, cp0_waddr, cp0_wdata  out  1/5/32  CP0 write port
- wb_stall  out  1  hold IF..MEM/WB; MEM/WB contents must not change while high
- load_wait_cnt  out  WAIT_CNT_W  total stall cycles caused by late loads

## Operation
- FSM states: RUN, WAIT_LOAD. Reset state RUN.
- RUN, wb_mreg=1, dm_rvalid=0: wb_stall=1, rf_we=0; next state WAIT_LOAD.
- RUN, wb_mreg=1, dm_rvalid=1: retire the load with no stall; stay RUN.
- RUN, wb_mreg=0: rf_we=wb_wreg, rf_wd=wb_dreg; dm_rvalid ignored.
- WAIT_LOAD, dm_rvalid=0: wb_stall=1, rf_we=0; stay.
- WAIT_LOAD, dm_rvalid=1: rf_we=wb_wreg, rf_wd=aligned data, wb_stall=0; next RUN.
- Load alignment: 1111 → word. 0011 → bits 15:0; 1100 → bits 31:16. 0001/0010/0100/1000 → the selected byte. Halfwords and bytes are extended per wb_sext. Any other code with wb_mreg=1 is treated as word.
- rf_wa=wb_wa always; rf_we is never high while wb_stall=1.
- HI/LO: hi_q/lo_q load wb_hilo on the clock edge when wb_whilo=1 and wb_stall=0. hi_o/lo_o = wb_hilo halves when wb_whilo=1, else hi_q/lo_q.
- CP0: cp0_we = wb_cp0_we & ~wb_stall; address and data pass through.
- load_wait_cnt increments on every cycle with wb_stall=1 and saturates at all-ones.

## Timing
- Reset values: state RUN, hi_q=lo_q=0, load_wait_cnt=0. Combinational outputs follow the inputs, so with an all-zero MEM/WB (reset or flush bubble): rf_we=0, cp0_we=0, wb_stall=0, hi_o=lo_o=0.
- GPR write: zero-latency; the register file samples rf_* at the next edge.
- Load latency: zero extra cycles if dm_rvalid arrives in the first WB cycle. Otherwise, one stall cycle per cycle of dm_rvalid low.
- wb_stall is combinational from state, wb_mreg and dm_rvalid, with no register on the path.
- Reset asserted in WAIT_LOAD: immediately RUN, wb_stall=0; the pending load is discarded.
- A HI/LO write is never coincident with a load. If wb_whilo=1 while stalled, the HI/LO write is deferred to the retiring cycle, because MEM/WB holds it.

## Structure
- Package mips32_wb_pkg:
  - state enum {RUN, WAIT_LOAD}
  - dre code constants: DRE_WORD, DRE_H0, DRE_H1, DRE_B0..DRE_B3
- Sub-module wb_load_align: combinational (dm_rdata, wb_dre, wb_sext) → 32-bit result.
- Top level holds the FSM, HI/LO registers, counter and output muxing.

## Test plan
- Reset then ALU write: wb_wreg=1, wb_wa=5, wb_dreg=0x12345678 → same cycle rf_we=1, rf_wa=5, rf_wd=0x12345678, wb_stall=0.
- LB from byte 3 with sign extension: dm_rdata=0x80FF0011, dre=1000, wb_sext=1, dm_rvalid=1 → rf_wd=0xFFFFFF80, no stall. Same stimulus with wb_sext=0 → rf_wd=0x00000080.
- Late load: dre=1100, wb_sext=0, dm_rvalid low 3 cycles then high with 0xABCD0000 → wb_stall high 3 cycles, rf_we=0 during them; then rf_wd=0x0000ABCD; load_wait_cnt=3.
- HI/LO: wb_whilo=1, wb_hilo=0x00000001_00000002 → hi_o=1, lo_o=2 in the same cycle. Next cycle with wb_whilo=0 → hi_o=1, lo_o=2 from registers.
- Reset mid-wait: enter WAIT_LOAD, assert rst for one cycle → wb_stall=0, rf_we=0, state RUN, hi_o=lo_o=0.
- CP0 during stall: wb_cp0_we=1 while wb_stall=1 → cp0_we=0. cp0_we=1 in the cycle the stall drops.

Source files
------------

// File: rtl/mips32_wb_pkg.sv
// mips32_wb_pkg
// Shared types and constants for the mips32 writeback stage:
//   - wb_state_e : load-wait FSM states (RUN, WAIT_LOAD)
//   - DRE_*      : byte-lane enable codes recognised by the load aligner
//   - ext_half / ext_byte : sign/zero extension helpers
package mips32_wb_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  localparam logic [3:0] DRE_WORD = 4'b1111;
  localparam logic [3:0] DRE_H0   = 4'b0011;
  localparam logic [3:0] DRE_H1   = 4'b1100;
  localparam logic [3:0] DRE_B0   = 4'b0001;
  localparam logic [3:0] DRE_B1   = 4'b0010;
  localparam logic [3:0] DRE_B2   = 4'b0100;
  localparam logic [3:0] DRE_B3   = 4'b1000;

  // Extend a halfword to 32 bits; sext selects sign vs zero extension.
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sext);
    return {{16{sext & h[15]}}, h};
  endfunction

  // Extend a byte to 32 bits; sext selects sign vs zero extension.
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sext);
    return {{24{sext & b[7]}}, b};
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align
// Purely combinational load-data aligner. Picks the word, halfword or byte
// addressed by the lane enables out of the data-memory read word, moves it
// to bit 0 and extends it.
// Ports:
//   rdata_i [31:0] data-memory read word
//   dre_i   [3:0]  byte-lane enables (lane 0 = bits 7:0)
//   sext_i         1 = sign-extend, 0 = zero-extend
//   data_o  [31:0] aligned, extended load result
module wb_load_align
  import mips32_wb_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [3:0]  dre_i,
  input  logic        sext_i,
  output logic [31:0] data_o
);

  // Lane select; unrecognised enable patterns fall back to a full word.
  always_comb begin
    data_o = rdata_i;
    case (dre_i)
      DRE_WORD: data_o = rdata_i;
      DRE_H0:   data_o = ext_half(rdata_i[15:0], sext_i);
      DRE_H1:   data_o = ext_half(rdata_i[31:16], sext_i);
      DRE_B0:   data_o = ext_byte(rdata_i[7:0], sext_i);
      DRE_B1:   data_o = ext_byte(rdata_i[15:8], sext_i);
      DRE_B2:   data_o = ext_byte(rdata_i[23:16], sext_i);
      DRE_B3:   data_o = ext_byte(rdata_i[31:24], sext_i);
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage
// Writeback stage of the mips32 pipeline. Selects GPR write data (ALU result
// or aligned load data), owns HI/LO, forwards CP0 writes and stalls the
// pipeline while a load response from data memory is outstanding.
// Ports:
//   clk, rst                     clock, async active-high reset
//   wb_*                         MEM/WB register contents
//   dm_rdata, dm_rvalid          data-memory read response
//   rf_we, rf_wa, rf_wd          GPR write port (sampled by the RF next edge)
//   hi_o, lo_o                   HI/LO read values, bypassing a pending write
//   cp0_we, cp0_waddr, cp0_wdata CP0 write port
//   wb_stall                     freeze IF..MEM/WB while a load is late
//   load_wait_cnt                saturating count of load stall cycles
module wb_stage
  import mips32_wb_pkg::*;
#(
  parameter int WAIT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           wb_dreg,
  input  logic [4:0]            wb_wa,
  input  logic                  wb_wreg,
  input  logic                  wb_mreg,
  input  logic [3:0]            wb_dre,
  input  logic                  wb_sext,
  input  logic                  wb_whilo,
  input  logic [63:0]           wb_hilo,
  input  logic                  wb_cp0_we,
  input  logic [4:0]            wb_cp0_waddr,
  input  logic [31:0]           wb_cp0_wdata,
  input  logic [31:0]           dm_rdata,
  input  logic                  dm_rvalid,
  output logic                  rf_we,
  output logic [4:0]            rf_wa,
  output logic [31:0]           rf_wd,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  cp0_we,
  output logic [4:0]            cp0_waddr,
  output logic [31:0]           cp0_wdata,
  output logic                  wb_stall,
  output logic [WAIT_CNT_W-1:0] load_wait_cnt
);

  wb_state_e             state_q, state_d;
  logic                  stall;
  logic [31:0]           load_data;
  logic [31:0]           hi_q, lo_q;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  wb_load_align u_align (
    .rdata_i (dm_rdata),
    .dre_i   (wb_dre),
    .sext_i  (wb_sext),
    .data_o  (load_data)
  );

  // Load-wait next state and stall. Stall is unregistered so a late response
  // freezes the pipeline in the very cycle it is found missing.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (wb_mreg && !dm_rvalid) begin
          stall   = 1'b1;
          state_d = WAIT_LOAD;
        end else begin
          stall   = 1'b0;
          state_d = RUN;
        end
      end
      WAIT_LOAD: begin
        if (dm_rvalid) begin
          stall   = 1'b0;
          state_d = RUN;
        end else begin
          stall   = 1'b1;
          state_d = WAIT_LOAD;
        end
      end
      default: begin
        stall   = 1'b0;
        state_d = RUN;
      end
    endcase
  end

  // Stall-cycle counter next value, holding at all-ones once saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {WAIT_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM state register; reset discards any pending load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // HI/LO registers; a write seen while stalled is replayed when the stall drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= 32'h0000_0000;
      lo_q <= 32'h0000_0000;
    end else if (wb_whilo && !stall) begin
      hi_q <= wb_hilo[63:32];
      lo_q <= wb_hilo[31:0];
    end
  end

  // Load-wait statistics counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {WAIT_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wb_stall      = stall;
  assign rf_we         = wb_wreg & ~stall;
  assign rf_wa         = wb_wa;
  // MEM/WB is frozen during WAIT_LOAD, so wb_mreg alone would do; the state
  // term keeps the load path selected even if a bubble sneaks in.
  assign rf_wd         = (wb_mreg || (state_q == WAIT_LOAD)) ? load_data : wb_dreg;
  assign hi_o          = wb_whilo ? wb_hilo[63:32] : hi_q;
  assign lo_o          = wb_whilo ? wb_hilo[31:0]  : lo_q;
  assign cp0_we        = wb_cp0_we & ~stall;
  assign cp0_waddr     = wb_cp0_waddr;
  assign cp0_wdata     = wb_cp0_wdata;
  assign load_wait_cnt = cnt_q;

endmodule
